// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and default widths for the ATM session controller
package atm_pkg;

  localparam int DIGIT_W_DEF = 4;
  localparam int SALDO_W_DEF = 4;
  localparam int TEMPO_W     = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER_PIN,
    S_CHECK,
    S_AUTH,
    S_PAY,
    S_EJECT
  } state_t;

  // Idle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [TEMPO_W-1:0] tempo_inc(input logic [TEMPO_W-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// rtl/atm_session_ctrl_if.sv - keypad/card/withdrawal bus between the user side and the controller (ATM_LOCKOUT_EN adds locked)
interface atm_session_ctrl_if
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = 4,
  parameter int DIGIT_W    = DIGIT_W_DEF,
  parameter int SALDO_W    = SALDO_W_DEF
);

  logic                          card_in;
  logic                          digit_valid;
  logic [DIGIT_W-1:0]            digit;
  logic [PIN_DIGITS*DIGIT_W-1:0] pin_ref;
  logic                          saldo_load;
  logic [SALDO_W-1:0]            saldo_init;
  logic                          op_valid;
  logic [SALDO_W-1:0]            op_value;

  logic                          pin_ok;
  logic                          eject_tries;
  logic                          eject_time;
  logic                          pay_valid;
  logic [SALDO_W-1:0]            pay_amount;
  logic                          insufficient;
  logic [SALDO_W-1:0]            saldo;
  logic [TEMPO_W-1:0]            tempo;
  logic                          busy;
`ifdef ATM_LOCKOUT_EN
  logic                          locked;
`endif

  modport master (
    output card_in, digit_valid, digit, pin_ref, saldo_load, saldo_init, op_valid, op_value,
    input  pin_ok, eject_tries, eject_time, pay_valid, pay_amount, insufficient, saldo, tempo, busy
`ifdef ATM_LOCKOUT_EN
    , input locked
`endif
  );

  modport slave (
    input  card_in, digit_valid, digit, pin_ref, saldo_load, saldo_init, op_valid, op_value,
    output pin_ok, eject_tries, eject_time, pay_valid, pay_amount, insufficient, saldo, tempo, busy
`ifdef ATM_LOCKOUT_EN
    , output locked
`endif
  );

endinterface

// File: rtl/atm_pin_buffer.sv
// rtl/atm_pin_buffer.sv - MSB-first PIN digit shift register, digit counter and reference comparator
module atm_pin_buffer #(
  parameter int PIN_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          shift,
  input  logic [DIGIT_W-1:0]            digit,
  input  logic [PIN_DIGITS*DIGIT_W-1:0] pin_ref,
  output logic                          full,
  output logic                          match
);

  localparam int BUF_W = PIN_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(PIN_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIN_DIGITS);

  logic [BUF_W-1:0] digits;
  logic [CNT_W-1:0] cnt;

  // Shift new digits in at the LSB so the first digit ends up in the MSBs; clr restarts the count only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits <= '0;
      cnt    <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift && (cnt != CNT_FULL)) begin
      digits <= {digits[BUF_W-DIGIT_W-1:0], digit};
      cnt    <= cnt + 1'b1;
    end
  end

  assign full  = (cnt == CNT_FULL);
  assign match = (digits == pin_ref);

endmodule

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session FSM: PIN check, tries/idle ejection, withdrawals (ATM_LOCKOUT_EN adds sticky lockout)
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS  = 4,
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 300,
  parameter int SALDO_W     = SALDO_W_DEF
) (
  input logic               clk,
  input logic               rst,
  atm_session_ctrl_if.slave bus
);

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRIES_W-1:0] TRIES_MAX   = TRIES_W'(MAX_TRIES);
  localparam logic [TEMPO_W-1:0] TEMPO_LIMIT = TEMPO_W'(TIMEOUT_CYC - 1);

  state_t               state, state_d;
  logic [TRIES_W-1:0]   tries;
  logic [TRIES_W-1:0]   tries_inc;
  logic [SALDO_W-1:0]   saldo_q;
  logic [SALDO_W-1:0]   op_q;
  logic [TEMPO_W-1:0]   tempo_q;
  logic                 eject_tries_q;
  logic                 eject_time_q;
  logic                 insuf_q;
  logic                 locked_q;

  logic                 buf_full;
  logic                 buf_match;
  logic                 buf_clr;
  logic                 digit_ev;
  logic                 op_ev;
  logic                 op_fits;
  logic                 timeout;
  logic                 start;
  logic                 cur_active;
  logic                 nxt_active;

  assign tries_inc  = tries + 1'b1;
  assign digit_ev   = (state == S_ENTER_PIN) && bus.digit_valid && !buf_full;
  assign op_ev      = (state == S_AUTH) && bus.op_valid;
  assign op_fits    = (bus.op_value <= saldo_q);
  assign timeout    = (tempo_q >= TEMPO_LIMIT);
  assign start      = bus.card_in && !locked_q;
  assign cur_active = (state == S_ENTER_PIN) || (state == S_AUTH);
  assign nxt_active = (state_d == S_ENTER_PIN) || (state_d == S_AUTH);
  assign buf_clr    = (state == S_IDLE) || ((state == S_CHECK) && !buf_match);

  atm_pin_buffer #(
    .PIN_DIGITS (PIN_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_pin_buffer (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .shift   (digit_ev),
    .digit   (bus.digit),
    .pin_ref (bus.pin_ref),
    .full    (buf_full),
    .match   (buf_match)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state: card removal beats everything, then completed entry, then events, then timeout.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_ENTER_PIN;
      end
      S_ENTER_PIN: begin
        if (!bus.card_in)            state_d = S_IDLE;
        else if (buf_full)           state_d = S_CHECK;
        else if (!digit_ev && timeout) state_d = S_EJECT;
      end
      S_CHECK: begin
        if (!bus.card_in)             state_d = S_IDLE;
        else if (buf_match)           state_d = S_AUTH;
        else if (tries_inc == TRIES_MAX) state_d = S_EJECT;
        else                          state_d = S_ENTER_PIN;
      end
      S_AUTH: begin
        if (!bus.card_in) state_d = S_IDLE;
        else if (op_ev) begin
          if (bus.op_value == '0) state_d = S_EJECT;
          else if (op_fits)       state_d = S_PAY;
        end else if (timeout)     state_d = S_EJECT;
      end
      S_PAY: begin
        if (!bus.card_in) state_d = S_IDLE;
        else              state_d = S_AUTH;
      end
      S_EJECT: begin
        if (!bus.card_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Session datapath: tries, balance, latched amount, idle counter and registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tries         <= '0;
      saldo_q       <= '0;
      op_q          <= '0;
      tempo_q       <= '0;
      eject_tries_q <= 1'b0;
      eject_time_q  <= 1'b0;
      insuf_q       <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start)            tries <= '0;
      else if ((state == S_CHECK) && !buf_match) tries <= tries_inc;

      if ((state == S_IDLE) && bus.saldo_load) saldo_q <= bus.saldo_init;
      else if (state == S_PAY)                 saldo_q <= (op_q > saldo_q) ? '0 : saldo_q - op_q;

      if (op_ev && (state_d == S_PAY)) op_q <= bus.op_value;

      // Idle time only accumulates while staying within ENTER_PIN/AUTH without an event.
      if (cur_active && nxt_active && !digit_ev && !op_ev) tempo_q <= tempo_inc(tempo_q);
      else                                                tempo_q <= '0;

      eject_tries_q <= (state == S_CHECK) && (state_d == S_EJECT);
      eject_time_q  <= cur_active && (state_d == S_EJECT) && !op_ev;
      insuf_q       <= op_ev && bus.card_in && (bus.op_value != '0) && !op_fits;
    end
  end

`ifdef ATM_LOCKOUT_EN
  // Sticky lockout after a tries ejection; only reset releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              locked_q <= 1'b0;
    else if ((state == S_CHECK) && (state_d == S_EJECT)) locked_q <= 1'b1;
  end
  assign bus.locked = locked_q;
`else
  assign locked_q = 1'b0;
`endif

  // State-decoded outputs.
  always_comb begin
    bus.pin_ok     = (state == S_AUTH) || (state == S_PAY);
    bus.busy       = (state != S_IDLE);
    bus.pay_valid  = (state == S_PAY);
    bus.pay_amount = (state == S_PAY) ? op_q : '0;
  end

  assign bus.eject_tries  = eject_tries_q;
  assign bus.eject_time   = eject_time_q;
  assign bus.insufficient = insuf_q;
  assign bus.saldo        = saldo_q;
  assign bus.tempo        = tempo_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - scoreboard bench for atm_session_ctrl
module tb_atm_session_ctrl;

  localparam int EV_PAY   = 1;
  localparam int EV_INSUF = 2;
  localparam int EV_ETRY  = 3;
  localparam int EV_ETIME = 4;

  typedef struct {
    int kind;
    int amount;
  } ev_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  ev_t  exp_q[$];
  ev_t  mon_e;
  int   mon_kind;
  int   mon_cnt;

  atm_session_ctrl_if #(.PIN_DIGITS(4), .DIGIT_W(4), .SALDO_W(4)) bus ();

  atm_session_ctrl #(
    .PIN_DIGITS (4),
    .DIGIT_W    (4),
    .MAX_TRIES  (3),
    .TIMEOUT_CYC(300),
    .SALDO_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int amount);
    ev_t e;
    e.kind   = kind;
    e.amount = amount;
    exp_q.push_back(e);
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = 0; i < 4; i++) begin
      bus.digit       = p[15-4*i -: 4];
      bus.digit_valid = 1'b1;
      step();
      bus.digit_valid = 1'b0;
    end
  endtask

  // Every output pulse is matched against the oldest expected event.
  always @(negedge clk) begin
    if (!rst) begin
      mon_kind = 0;
      mon_cnt  = 0;
      if (bus.pay_valid)    begin mon_kind = EV_PAY;   mon_cnt++; end
      if (bus.insufficient) begin mon_kind = EV_INSUF; mon_cnt++; end
      if (bus.eject_tries)  begin mon_kind = EV_ETRY;  mon_cnt++; end
      if (bus.eject_time)   begin mon_kind = EV_ETIME; mon_cnt++; end
      if (mon_cnt > 1) begin
        tests++;
        fails++;
        $display("FAIL multi_pulse: got %0d simultaneous pulses expected 1", mon_cnt);
      end else if (mon_kind != 0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: got kind %0d expected none", mon_kind);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind != mon_kind) begin
            fails++;
            $display("FAIL pulse_kind: got %0d expected %0d", mon_kind, mon_e.kind);
          end else if ((mon_kind == EV_PAY) && (int'(bus.pay_amount) != mon_e.amount)) begin
            fails++;
            $display("FAIL pay_amount: got %0d expected %0d", bus.pay_amount, mon_e.amount);
          end
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    bus.card_in     = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit       = '0;
    bus.pin_ref     = 16'h1234;
    bus.saldo_load  = 1'b0;
    bus.saldo_init  = '0;
    bus.op_valid    = 1'b0;
    bus.op_value    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_pin_ok", bus.pin_ok, 0);
    check("rst_saldo", bus.saldo, 0);
    check("rst_tempo", bus.tempo, 0);
    rst = 1'b0;
    step();

    // Balance load and a good PIN with two withdrawals.
    bus.saldo_init = 4'd9;
    bus.saldo_load = 1'b1;
    step();
    bus.saldo_load = 1'b0;
    check("saldo_loaded", bus.saldo, 9);
    bus.card_in = 1'b1;
    step();
    check("enter_busy", bus.busy, 1);
    check("enter_tempo", bus.tempo, 0);
    enter_pin(16'h1234);
    check("pin_ok_n", bus.pin_ok, 0);
    step();
    check("pin_ok_n1", bus.pin_ok, 0);
    step();
    check("pin_ok_n2", bus.pin_ok, 1);
    repeat (5) step();
    check("auth_tempo", bus.tempo, 5);
    push(EV_PAY, 3);
    bus.op_value = 4'd3;
    bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0;
    check("pay_state_pin_ok", bus.pin_ok, 1);
    step();
    check("saldo_after_pay", bus.saldo, 6);
    push(EV_INSUF, 0);
    bus.op_value = 4'd7;
    bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0;
    step();
    check("saldo_after_insuf", bus.saldo, 6);
    check("still_auth", bus.pin_ok, 1);
    bus.op_value = 4'd0;
    bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0;
    check("end_eject_busy", bus.busy, 1);
    check("end_eject_pin_ok", bus.pin_ok, 0);
    bus.card_in = 1'b0;
    step();
    check("end_idle", bus.busy, 0);

    // Three wrong PINs.
    bus.card_in = 1'b1;
    step();
    for (int a = 0; a < 3; a++) begin
      enter_pin(16'h0000);
      step();
      if (a == 2) push(EV_ETRY, 0);
      step();
      check("wrong_pin_ok", bus.pin_ok, 0);
      check("wrong_busy", bus.busy, 1);
    end
    step();
    check("eject_hold_busy", bus.busy, 1);
    bus.card_in = 1'b0;
    step();
    check("tries_idle", bus.busy, 0);
`ifdef ATM_LOCKOUT_EN
    check("locked_set", bus.locked, 1);
    bus.card_in = 1'b1;
    step();
    step();
    check("locked_busy", bus.busy, 0);
    bus.card_in = 1'b0;
    rst = 1'b1;
    step();
    check("locked_rst", bus.locked, 0);
    rst = 1'b0;
    step();
`endif

    // Idle timeout; a digit at tempo 298 rescues the session.
    bus.card_in = 1'b1;
    step();
    repeat (298) step();
    check("tempo_298", bus.tempo, 298);
    bus.digit       = 4'd1;
    bus.digit_valid = 1'b1;
    step();
    bus.digit_valid = 1'b0;
    check("tempo_cleared", bus.tempo, 0);
    check("rescued_busy", bus.busy, 1);
    repeat (299) step();
    check("tempo_299", bus.tempo, 299);
    push(EV_ETIME, 0);
    step();
    check("timeout_tempo", bus.tempo, 0);
    check("timeout_busy", bus.busy, 1);
    bus.card_in = 1'b0;
    step();
    check("timeout_idle", bus.busy, 0);

    // Card pulled mid-PIN.
    bus.card_in = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      bus.digit       = 4'(i + 1);
      bus.digit_valid = 1'b1;
      step();
      bus.digit_valid = 1'b0;
    end
    bus.card_in = 1'b0;
    step();
    check("drop_idle", bus.busy, 0);
    step();

    // Asynchronous reset while authenticated.
    bus.saldo_init = 4'd5;
    bus.saldo_load = 1'b1;
    step();
    bus.saldo_load = 1'b0;
    bus.card_in = 1'b1;
    step();
    enter_pin(16'h1234);
    step();
    step();
    check("rst_auth_pin_ok", bus.pin_ok, 1);
    check("rst_auth_saldo", bus.saldo, 5);
    #2;
    rst = 1'b1;
    #1;
    check("async_pin_ok", bus.pin_ok, 0);
    check("async_busy", bus.busy, 0);
    check("async_saldo", bus.saldo, 0);
    bus.card_in = 1'b0;
    step();
    rst = 1'b0;
    step();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
